// File: rtl/color_codec_pkg.sv
// Shared types and constants for the colour codec: FSM states,
// RGB444 digit palette, code field positions and BCD sizing helper.
package color_codec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [11:0] PAL_0     = 12'h000;
  localparam logic [11:0] PAL_1     = 12'hF00;
  localparam logic [11:0] PAL_2     = 12'h0F0;
  localparam logic [11:0] PAL_3     = 12'h00F;
  localparam logic [11:0] PAL_4     = 12'hFF0;
  localparam logic [11:0] PAL_5     = 12'h0FF;
  localparam logic [11:0] PAL_6     = 12'hF0F;
  localparam logic [11:0] PAL_7     = 12'hFFF;
  localparam logic [11:0] PAL_8     = 12'hF80;
  localparam logic [11:0] PAL_9     = 12'h888;
  localparam logic [11:0] PAL_BLANK = 12'h000;

  localparam int CODE_TENS_HI  = 23;
  localparam int CODE_TENS_LO  = 12;
  localparam int CODE_UNITS_HI = 11;
  localparam int CODE_UNITS_LO = 0;

  // Decimal digits needed for a w-bit unsigned value (log10(2) ~ 0.301).
  function automatic int bcd_digits(input int w);
    return (w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/color_palette.sv
// Combinational digit-to-colour lookup.
// Ports: digit_i (4-bit BCD digit) -> rgb_o (12-bit RGB444).
module color_palette
  import color_codec_pkg::*;
(
  input  logic [3:0]  digit_i,
  output logic [11:0] rgb_o
);

  always_comb begin
    rgb_o = PAL_BLANK;
    case (digit_i)
      4'd0:    rgb_o = PAL_0;
      4'd1:    rgb_o = PAL_1;
      4'd2:    rgb_o = PAL_2;
      4'd3:    rgb_o = PAL_3;
      4'd4:    rgb_o = PAL_4;
      4'd5:    rgb_o = PAL_5;
      4'd6:    rgb_o = PAL_6;
      4'd7:    rgb_o = PAL_7;
      4'd8:    rgb_o = PAL_8;
      4'd9:    rgb_o = PAL_9;
      default: rgb_o = PAL_BLANK;
    endcase
  end

endmodule

// File: rtl/color_codec.sv
// Converts an unsigned word to two RGB444 colours (tens, units digit)
// via a bit-serial double-dabble. Ports: clk, rst_n (async low),
// in_data/in_valid/in_ready handshake, code[23:0], code_upd pulse.
// Option: COLOR_CODEC_SATURATE_EN shows values > 99 as 99.
module color_codec
  import color_codec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [23:0]       code,
  output logic              code_upd
);

  localparam int BCD_W = 4 * bcd_digits(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [23:0]         code_q, code_d;
  logic                upd_q, upd_d;
  logic [BCD_W+DATA_W-1:0] cat;
  logic [3:0]          tens, units;
  logic [11:0]         rgb_tens, rgb_units;

`ifdef COLOR_CODEC_SATURATE_EN
  logic big_q, big_d;
  assign tens  = big_q ? 4'd9 : bcd_q[7:4];
  assign units = big_q ? 4'd9 : bcd_q[3:0];
`else
  assign tens  = bcd_q[7:4];
  assign units = bcd_q[3:0];
`endif

  color_palette u_pal_tens (
    .digit_i (tens),
    .rgb_o   (rgb_tens)
  );

  color_palette u_pal_units (
    .digit_i (units),
    .rgb_o   (rgb_units)
  );

  // One double-dabble step: add 3 to digits >= 5, then shift the
  // BCD and binary registers together by one bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    cat = {bcd_adj, sh_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    upd_d   = 1'b0;
`ifdef COLOR_CODEC_SATURATE_EN
    big_d   = big_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_CONVERT;
`ifdef COLOR_CODEC_SATURATE_EN
          big_d   = 32'(in_data) > 32'd99;
`endif
        end
      end
      ST_CONVERT: begin
        bcd_d = cat[BCD_W+DATA_W-1:DATA_W];
        sh_d  = cat[DATA_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        code_d[CODE_TENS_HI:CODE_TENS_LO]   = rgb_tens;
        code_d[CODE_UNITS_HI:CODE_UNITS_LO] = rgb_units;
        upd_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      upd_q   <= 1'b0;
`ifdef COLOR_CODEC_SATURATE_EN
      big_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
`ifdef COLOR_CODEC_SATURATE_EN
      big_q   <= big_d;
`endif
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign code     = code_q;
  assign code_upd = upd_q;

endmodule

// File: tb/tb_color_codec.sv
// Self-checking bench for color_codec: behavioural model plus
// directed literal cases and randomized traffic.
module tb_color_codec;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [23:0]       code;
  logic              code_upd;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  color_codec #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
    .code_upd (code_upd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [11:0] pal [10] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                            12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
                            12'hF80, 12'h888};

  function automatic logic [23:0] exp_code(input int unsigned v);
    int unsigned d;
`ifdef COLOR_CODEC_SATURATE_EN
    if (v > 99) return 24'h888888;
`endif
    d = v % 100;
    return {pal[d / 10], pal[d % 10]};
  endfunction

  // Model: a transfer makes the block busy for DATA_W+1 edges; the
  // last of those loads the code and raises the update pulse.
  int          m_busy = 0;
  logic [23:0] m_code = '0;
  logic        m_upd = 1'b0;
  int unsigned m_val = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_code <= '0;
      m_upd  <= 1'b0;
    end else begin
      m_upd <= 1'b0;
      if (m_busy == 0) begin
        if (in_valid) begin
          m_val  <= int'(in_data);
          m_busy <= DATA_W + 1;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_code <= exp_code(m_val);
          m_upd  <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("code", 32'(code), 32'(m_code));
    chk("ready", 32'(in_ready), 32'(m_busy == 0));
    chk("upd", 32'(code_upd), 32'(m_upd));
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] v, output int t0);
    wait_ready();
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    t0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_upd(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (code_upd) begin
        at = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL upd_timeout: got none want pulse");
  endtask

  initial begin
    int t0, t1, t2, nupd;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (30) @(negedge clk);
    chk("idle_code", 32'(code), 32'h0);
    chk("idle_ready", 32'(in_ready), 32'h1);
    chk("idle_upd", 32'(code_upd), 32'h0);

    send(16'd42, t0);
    wait_upd(t1);
    chk("c42", 32'(code), 32'hFF00F0);
    chk("lat42", 32'(t1 - t0), 32'(DATA_W + 1));

    wait_ready();
    in_valid = 1'b1;
    in_data  = 16'd7;
    @(negedge clk);
    in_data  = 16'd0;
    wait_upd(t1);
    chk("c7", 32'(code), 32'h000FFF);
    @(negedge clk);
    in_valid = 1'b0;
    wait_upd(t2);
    chk("c0", 32'(code), 32'h000000);
    chk("b2b_gap", 32'(t2 - t1), 32'(DATA_W + 2));

    send(16'd1234, t0);
    wait_upd(t1);
`ifdef COLOR_CODEC_SATURATE_EN
    chk("c1234", 32'(code), 32'h888888);
`else
    chk("c1234", 32'(code), 32'h00FFF0);
`endif

    send(16'hFFFF, t0);
    wait_upd(t1);
`ifdef COLOR_CODEC_SATURATE_EN
    chk("c65535", 32'(code), 32'h888888);
`else
    chk("c65535", 32'(code), 32'h00F0FF);
`endif

    send(16'd42, t0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    nupd = 0;
    repeat (30) begin
      @(negedge clk);
      if (code_upd) nupd++;
    end
    chk("no_upd", 32'(nupd), 32'h0);
    chk("abort_code", 32'(code), 32'h0);
    send(16'd99, t0);
    wait_upd(t1);
    chk("c99", 32'(code), 32'h888888);

    repeat (1500) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom)
                                             : DATA_W'($urandom_range(0, 120));
    end
    in_valid = 1'b0;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
